// File: rtl/riscv_pkg.sv
// RV32I definitions shared by the issue queue and the decode/control units:
// opcode constants, instruction field extractors and the ALU operation encoding.
package riscv_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } aluop_e;

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] instr);
    return instr[24:20];
  endfunction

endpackage

// File: rtl/pair_hazard_check.sv
// Decides whether the second-oldest instruction may issue alongside the oldest:
// both must be ALU R/I-type, with no RAW/WAW hazard and distinct write banks.
module pair_hazard_check
  import riscv_pkg::*;
(
  input  logic [31:0] i0,
  input  logic [31:0] i1,
  output logic        pairable
);

  logic [6:0] op0, op1;
  logic [4:0] rd0, rd1;
  logic       alu0, alu1, rd0_live, rd1_live;
  logic       raw, waw, bank;
  logic       unused_bits;

  assign unused_bits = ^{i0, i1};

  always_comb begin
    op0      = opcode_of(i0);
    op1      = opcode_of(i1);
    rd0      = rd_of(i0);
    rd1      = rd_of(i1);
    alu0     = (op0 == OPC_RTYPE) || (op0 == OPC_ITYPE);
    alu1     = (op1 == OPC_RTYPE) || (op1 == OPC_ITYPE);
    rd0_live = (rd0 != 5'd0);
    rd1_live = (rd1 != 5'd0);
    // x0 is never written, so a zero destination cannot create a hazard or use a bank
    raw      = rd0_live && ((rs1_of(i1) == rd0) ||
                            ((op1 == OPC_RTYPE) && (rs2_of(i1) == rd0)));
    waw      = rd0_live && rd1_live && (rd1 == rd0);
    bank     = rd0_live && rd1_live && (rd0[0] == rd1[0]);
    pairable = alu0 && alu1 && !raw && !waw && !bank;
  end

endmodule

// File: rtl/dual_issue_queue.sv
// Circular instruction FIFO feeding two decode slots; slot 1 is offered only
// when the two oldest entries can issue together without hazards.
module dual_issue_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            in_instr,
  output logic                       in_ready,
  input  logic                       out_ready,
  output logic                       out0_valid,
  output logic [XLEN-1:0]            out0_instr,
  output logic                       out1_valid,
  output logic [XLEN-1:0]            out1_instr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [XLEN-1:0] head_instr, next_instr;
  logic            pairable;
  logic            push;
  logic [1:0]      pop;

  assign head_instr = mem_q[rd_ptr_q];
  assign next_instr = mem_q[rd_ptr_q + AW'(1)];

  pair_hazard_check u_pair_hazard_check (
    .i0       (head_instr),
    .i1       (next_instr),
    .pairable (pairable)
  );

  always_comb begin
    in_ready   = (count_q < FULL_CNT);
    out0_valid = (count_q != '0);
    out1_valid = (count_q >= CW'(2)) && pairable;
    out0_instr = out0_valid ? head_instr : '0;
    out1_instr = out1_valid ? next_instr : '0;
    count      = count_q;

    push = in_valid && in_ready;
    pop  = out_ready ? (2'(out0_valid) + 2'(out1_valid)) : 2'd0;

    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; validity comes entirely from count_q.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= in_instr;
    end
  end

endmodule

// File: tb/tb_dual_issue_queue.sv
// Directed bench for dual_issue_queue: a table of instruction pairs with
// hand-computed pairability, plus sequences for fill/wrap, flush and reset.
module tb_dual_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_ready;
  logic        out0_valid;
  logic [31:0] out0_instr;
  logic        out1_valid;
  logic [31:0] out1_instr;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dual_issue_queue #(.DEPTH(8), .XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .out0_valid (out0_valid),
    .out0_instr (out0_instr),
    .out1_valid (out1_valid),
    .out1_instr (out1_instr),
    .count      (count)
  );

  typedef struct {
    logic [31:0] i0;
    logic [31:0] i1;
    logic        pair;
  } pair_vec_t;

  pair_vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs are changed and outputs sampled at the falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    cycle();
    in_valid = 1'b0;
    in_instr = '0;
  endtask

  function automatic logic [31:0] addi(input int unsigned rd, input int unsigned imm);
    return (32'(imm) << 20) | (32'(rd) << 7) | 32'h13;
  endfunction

  logic [31:0] fill [9];

  initial begin
    vecs[0]  = '{32'h003100B3, 32'h00418133, 1'b1}; // independent, banks 1/0
    vecs[1]  = '{32'h003100B3, 32'h00508233, 1'b0}; // RAW on rs1
    vecs[2]  = '{32'h003100B3, 32'h005201B3, 1'b0}; // both rd odd
    vecs[3]  = '{32'h003100B3, 32'h00000013, 1'b1}; // nop, rd x0
    vecs[4]  = '{32'h003100B3, 32'h00118133, 1'b0}; // RAW on R-type rs2
    vecs[5]  = '{32'h003100B3, 32'h00118113, 1'b1}; // I-type imm looks like rs2=x1
    vecs[6]  = '{32'h003100B3, 32'h003100B3, 1'b0}; // WAW
    vecs[7]  = '{32'h003100B3, 32'h0001A103, 1'b0}; // load in slot 1
    vecs[8]  = '{32'h00208033, 32'h000002B3, 1'b1}; // i0 writes x0, i1 reads x0
    vecs[9]  = '{32'h00208033, 32'h00418033, 1'b1}; // both write x0
    vecs[10] = '{32'h00500093, 32'h00001137, 1'b0}; // LUI in slot 1
    vecs[11] = '{32'h00000063, 32'h00418133, 1'b0}; // branch in slot 0
    vecs[12] = '{32'h00100113, 32'h000101B3, 1'b0}; // RAW after ADDI
    vecs[13] = '{32'h00100113, 32'h005201B3, 1'b1}; // independent after ADDI

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    repeat (2) cycle();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out0_instr", out0_instr, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    cycle();

    // single push, no pop
    push(32'h003100B3);
    chk("one_out0_valid", 32'(out0_valid), 32'd1);
    chk("one_out0_instr", out0_instr, 32'h003100B3);
    chk("one_out1_valid", 32'(out1_valid), 32'd0);
    chk("one_out1_instr", out1_instr, 32'h0);
    chk("one_count", 32'(count), 32'd1);

    // second push makes a pair; both pop together
    push(32'h00418133);
    chk("pair_out1_valid", 32'(out1_valid), 32'd1);
    chk("pair_out1_instr", out1_instr, 32'h00418133);
    chk("pair_count", 32'(count), 32'd2);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("pair_pop_count", 32'(count), 32'd0);
    chk("pair_pop_valid", 32'(out0_valid), 32'd0);

    // RAW pair issues serially
    push(32'h003100B3);
    push(32'h00508233);
    chk("raw_out1_valid", 32'(out1_valid), 32'd0);
    out_ready = 1'b1;
    cycle();
    chk("raw_pop1_count", 32'(count), 32'd1);
    chk("raw_pop1_out0", out0_instr, 32'h00508233);
    cycle();
    chk("raw_pop2_count", 32'(count), 32'd0);

    // push and pop together at count=1
    out_ready = 1'b0;
    push(32'h003100B3);
    out_ready = 1'b1;
    push(32'h00418133);
    chk("pp_count", 32'(count), 32'd1);
    chk("pp_out0", out0_instr, 32'h00418133);
    cycle();
    chk("pp_drain", 32'(count), 32'd0);
    out_ready = 1'b0;

    // pairability table
    foreach (vecs[k]) begin
      push(vecs[k].i0);
      push(vecs[k].i1);
      chk($sformatf("vec%0d_out0", k), out0_instr, vecs[k].i0);
      chk($sformatf("vec%0d_out1_valid", k), 32'(out1_valid), 32'(vecs[k].pair));
      chk($sformatf("vec%0d_out1", k), out1_instr, vecs[k].pair ? vecs[k].i1 : 32'h0);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      chk($sformatf("vec%0d_flushed", k), 32'(count), 32'd0);
    end

    // move pointers off zero so the fill below wraps
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00500093;
    repeat (3) cycle();
    in_valid = 1'b0;
    cycle();
    chk("pre_fill_count", 32'(count), 32'd0);
    out_ready = 1'b0;

    // overfill: 8 accepted, 9th refused
    for (int i = 0; i < 9; i++) fill[i] = addi(i + 1, i);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("fill%0d_in_ready", i), 32'(in_ready), (i < 8) ? 32'd1 : 32'd0);
      push(fill[i]);
    end
    chk("full_count", 32'(count), 32'd8);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("drain%0d_out0", p), out0_instr, fill[2*p]);
      chk($sformatf("drain%0d_out1_valid", p), 32'(out1_valid), 32'd1);
      chk($sformatf("drain%0d_out1", p), out1_instr, fill[2*p+1]);
      cycle();
    end
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_valid", 32'(out0_valid), 32'd0);
    out_ready = 1'b0;

    // flush wins over simultaneous push and pop
    for (int i = 0; i < 5; i++) push(fill[i]);
    chk("pre_flush_count", 32'(count), 32'd5);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h005201B3; out_ready = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out0_valid", 32'(out0_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    push(32'h00418133);
    chk("post_flush_out0", out0_instr, 32'h00418133);
    chk("post_flush_count", 32'(count), 32'd1);

    // asynchronous reset mid-stream
    push(fill[0]);
    push(fill[1]);
    rst_n = 1'b0;
    #1;
    chk("arst_out0_valid", 32'(out0_valid), 32'd0);
    chk("arst_out0_instr", out0_instr, 32'h0);
    chk("arst_out1_valid", 32'(out1_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("post_rst_valid", 32'(out0_valid), 32'd0);
    chk("post_rst_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/dual_issue_queue.md
Name: dual_issue_queue

Overview:
- Instruction buffer and pair-issue stage directly upstream of the two decode/control units of the superscalar datapath.
- Accepts one 32-bit RV32I instruction per cycle from fetch over a valid/ready handshake and holds it in a circular FIFO.
- Each cycle it presents the oldest one or two instructions to decode slots 0 and 1. Slot 1 is offered only when the pair is free of intra-pair hazards and register-file write-bank conflicts.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
XLEN, 32, instruction width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous queue clear (branch redirect)
in_valid  input  1  fetch presents in_instr
in_instr  input  XLEN  instruction word
in_ready  output  1  queue can accept this cycle
out_ready  input  1  decode accepts the offered slot(s) this cycle
out0_valid  output  1  slot 0 holds the oldest instruction
out0_instr  output  XLEN  oldest instruction; 0 when !out0_valid
out1_valid  output  1  slot 1 holds the second-oldest, pairable instruction
out1_instr  output  XLEN  second-oldest; 0 when !out1_valid
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async assert, sync release): rd_ptr=0, wr_ptr=0, count=0, out0_valid=0, out1_valid=0, both out*_instr=0, in_ready=1. Storage array is not reset.
- Push: in_ready = (count < DEPTH). Push occurs when in_valid && in_ready; a write at edge N is visible on out0 in cycle N+1 (1-cycle latency, no bypass).
- Offer: out0_valid = (count >= 1).
- out1_valid = (count >= 2) && pairable(head, head+1). Both outputs are combinational from registered storage and pointers.
- pairable(i0, i1) requires all of the following:
  - both opcodes are in {7'b0110011 R-type, 7'b0010011 I-type}; any other opcode issues alone in slot 0;
  - no RAW: i1.rs1 != i0.rd, and for R-type i1 also i1.rs2 != i0.rd; the rs2 field of an I-type i1 is ignored;
  - no WAW: i1.rd != i0.rd;
  - no bank conflict: i0.rd[0] != i1.rd[0].
  - Any rd == x0 is exempt from the RAW, WAW and bank checks (x0 is never written).
- Pop: when out_ready=1, pop = out0_valid + out1_valid (0, 1 or 2). rd_ptr advances by pop modulo DEPTH.
- Occupancy: count_next = count + push - pop. Push and pop in the same cycle are legal, including when count=1 and the new entry is the one being written.
- Pointers: wrap naturally at DEPTH. Full/empty are derived from count, not pointer compare.
- Flush: highest priority. Next state is rd_ptr=wr_ptr=0, count=0; a push or pop in the same cycle is discarded. Outputs are invalid the cycle after.
- Reset mid-operation: all entries are discarded immediately; no instruction may be re-offered after release.
- When out_ready=0, offered slots and their validity stay stable except where a push changes the pairability of slot 1 (count 1 -> 2).

Decomposition:
- Shared package riscv_pkg:
  - OPC_RTYPE = 7'b0110011, OPC_ITYPE = 7'b0010011;
  - field-extract functions rd_of, rs1_of, rs2_of, opcode_of;
  - the ALUop encodings used by decode.
- Sub-module pair_hazard_check: purely combinational, inputs i0/i1, output pairable. It is unit-tested in isolation.
- The FIFO, pointers and handshake stay in dual_issue_queue.

Test Plan:
- Reset, push ADD x1,x2,x3 (0x003100B3), out_ready=0 -> next cycle out0_valid=1, out0_instr=0x003100B3, out1_valid=0, count=1.
- Push 0x003100B3 then ADD x2,x3,x4 (0x00418133), then out_ready=1 -> out1_valid=1 (rd banks 1/0, no RAW); both pop in one cycle; count 2->0.
- Push 0x003100B3 then ADD x4,x1,x5 (0x00508233) -> out1_valid=0 (RAW on x1). Cycle 1 pops only slot 0; next cycle 0x00508233 is on out0.
- Push 0x003100B3 then ADD x3,x4,x5 (0x005201B3) -> out1_valid=0 (both rd odd). Replacing the second with ADDI x0,x0,0 (0x00000013) -> out1_valid=1.
- out_ready=0, push 9 instructions back-to-back -> in_ready=0 after the 8th, 9th not accepted, count=8. Then drain 2/cycle with independent pairs and verify wrap-around order.
- Queue at count=5, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out0_valid=0. Assert rst_n=0 mid-stream -> outputs 0 in the same cycle.
